// File: rtl/fft_spectrum_peak.sv
// rtl/fft_spectrum_peak.sv - per-bin magnitude and per-frame peak tracker for an FFT result stream
//
// Purpose:
//   Consumes the FFT output controller's result stream. For each accepted bin it
//   computes |X| ~= max(|re|,|im|) + min(|re|,|im|)/2 and forwards it as a magnitude
//   stream with a fixed latency of 3 cycles. For each completed frame it reports
//   the peak bin (ties keep the lowest index). The FFT has no backpressure, so
//   every valid beat is taken.
//
// Ports:
//   i_aclk, i_rst            clock, synchronous active-high reset
//   i_axi4s_data_*           FFT result beats (re low field, im high field, bin in tuser)
//   o_mag_*                  magnitude stream (valid, magnitude, bin index, last forwarded bin)
//   o_peak_vld               one-cycle pulse, one cycle after the o_mag_tlast beat
//   o_peak_index/o_peak_mag  peak of the last completed frame, held until the next report
//   o_frame_err              one-cycle pulse on a bin-sequence error
//
// Optional feature macro: FFT_SPEC_FRAME_CHECK_EN
//   Defined: bin-continuity / tlast checking in RUN; an error drops the rest of the
//   frame and suppresses its peak report. Undefined: o_frame_err is tied to 0.

module fft_spectrum_peak #(
  parameter int LOG2_FFT_LEN  = 8,
  parameter int OUT_WIDTH     = 25,
  parameter int DATA_WIDTH    = 32,
  parameter int USER_WIDTH    = 16,
  parameter int HALF_SPECTRUM = 1,
  parameter int SKIP_DC       = 1
) (
  input  logic                    i_aclk,
  input  logic                    i_rst,
  input  logic                    i_axi4s_data_tvalid,
  input  logic [2*DATA_WIDTH-1:0] i_axi4s_data_tdata,
  input  logic                    i_axi4s_data_tlast,
  input  logic [USER_WIDTH-1:0]   i_axi4s_data_tuser,
  output logic                    o_mag_tvalid,
  output logic [OUT_WIDTH:0]      o_mag_tdata,
  output logic [LOG2_FFT_LEN-1:0] o_mag_index,
  output logic                    o_mag_tlast,
  output logic                    o_peak_vld,
  output logic [LOG2_FFT_LEN-1:0] o_peak_index,
  output logic [OUT_WIDTH:0]      o_peak_mag,
  output logic                    o_frame_err
);

  localparam int IW = LOG2_FFT_LEN;
  localparam int AW = OUT_WIDTH - 1;  // |x| never exceeds 2^(OUT_WIDTH-1)-1 after saturation
  localparam int MW = OUT_WIDTH + 1;
  localparam logic [IW-1:0] LAST_HALF = {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0] FIRST_BIN = (SKIP_DC != 0) ? IW'(1) : '0;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [OUT_WIDTH-1:0] w_re, w_im;
  logic [IW-1:0]        w_idx;
  logic                 w_in_range, w_last_fwd, w_accept, w_seq_bad;
  logic                 w_unused;

  assign w_re  = i_axi4s_data_tdata[OUT_WIDTH-1:0];
  assign w_im  = i_axi4s_data_tdata[DATA_WIDTH +: OUT_WIDTH];
  assign w_idx = i_axi4s_data_tuser[IW-1:0];
  // Padding bits of tdata/tuser carry no information.
  assign w_unused = ^{i_axi4s_data_tdata, i_axi4s_data_tuser, i_axi4s_data_tlast};

  // In half-spectrum mode the upper half of the frame is never forwarded.
  assign w_in_range = (HALF_SPECTRUM == 0) || !w_idx[IW-1];
  assign w_last_fwd = (HALF_SPECTRUM != 0) ? (w_idx == LAST_HALF) : i_axi4s_data_tlast;

  function automatic logic [AW-1:0] f_abs(input logic [OUT_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] neg;
    neg = -v;
    if (!v[OUT_WIDTH-1])       return v[AW-1:0];
    else if (v[AW-1:0] == '0)  return '1;  // most negative value saturates
    else                       return neg[AW-1:0];
  endfunction

`ifdef FFT_SPEC_FRAME_CHECK_EN
  logic [IW-1:0] r_prev_idx, w_idx_exp;
  logic          r_frame_err, w_err;

  assign w_idx_exp = r_prev_idx + 1'b1;
  assign w_seq_bad = (w_idx != w_idx_exp) || (i_axi4s_data_tlast && (w_idx != '1));
  assign w_err     = (r_state == ST_RUN) && i_axi4s_data_tvalid && w_seq_bad;

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      r_prev_idx  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_accept) r_prev_idx <= w_idx;
    end
  end

  assign o_frame_err = r_frame_err;
`else
  assign w_seq_bad   = 1'b0;
  assign o_frame_err = 1'b0;
`endif

  // Frame sequencing: IDLE resyncs on bin 0, RUN ends at the last forwarded bin.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (r_state == ST_IDLE) begin
      if (i_axi4s_data_tvalid && (w_idx == '0)) begin
        w_accept    = 1'b1;
        w_state_nxt = w_last_fwd ? ST_IDLE : ST_RUN;
      end
    end else begin
      if (i_axi4s_data_tvalid) begin
        if (w_seq_bad) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_accept = w_in_range;
          if (w_in_range && w_last_fwd) w_state_nxt = ST_IDLE;
        end
      end
    end
  end

  logic          r_s1_vld, r_s2_vld, r_s3_vld;
  logic          r_s1_last, r_s2_last, r_s3_last;
  logic [IW-1:0] r_s1_idx, r_s2_idx, r_s3_idx;
  logic [AW-1:0] r_s1_re, r_s1_im, r_s2_mx, r_s2_mn;
  logic [MW-1:0] r_s3_mag;
  logic [IW-1:0] r_run_idx, r_peak_idx;
  logic [MW-1:0] r_run_mag, r_peak_mag;
  logic          r_peak_vld;

  logic          w_searched, w_take;
  logic [IW-1:0] w_cand_idx;
  logic [MW-1:0] w_cand_mag;

  // The first searched bin loads unconditionally; later bins need a strictly larger
  // magnitude so that ties keep the lowest index.
  assign w_searched = !((SKIP_DC != 0) && (r_s3_idx == '0));
  assign w_take     = w_searched && ((r_s3_idx == FIRST_BIN) || (r_s3_mag > r_run_mag));
  assign w_cand_idx = w_take ? r_s3_idx : r_run_idx;
  assign w_cand_mag = w_take ? r_s3_mag : r_run_mag;

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_s1_vld   <= 1'b0;  r_s2_vld  <= 1'b0;  r_s3_vld  <= 1'b0;
      r_s1_last  <= 1'b0;  r_s2_last <= 1'b0;  r_s3_last <= 1'b0;
      r_s1_idx   <= '0;    r_s2_idx  <= '0;    r_s3_idx  <= '0;
      r_s1_re    <= '0;    r_s1_im   <= '0;
      r_s2_mx    <= '0;    r_s2_mn   <= '0;
      r_s3_mag   <= '0;
      r_run_idx  <= '0;    r_run_mag <= '0;
      r_peak_vld <= 1'b0;
      r_peak_idx <= '0;    r_peak_mag <= '0;
    end else begin
      r_state   <= w_state_nxt;
      // S1: absolute values
      r_s1_vld  <= w_accept;
      r_s1_re   <= f_abs(w_re);
      r_s1_im   <= f_abs(w_im);
      r_s1_idx  <= w_idx;
      r_s1_last <= w_last_fwd;
      // S2: ordering
      r_s2_vld  <= r_s1_vld;
      r_s2_mx   <= (r_s1_re >= r_s1_im) ? r_s1_re : r_s1_im;
      r_s2_mn   <= (r_s1_re >= r_s1_im) ? r_s1_im : r_s1_re;
      r_s2_idx  <= r_s1_idx;
      r_s2_last <= r_s1_last;
      // S3: alpha-max-plus-beta-min magnitude
      r_s3_vld  <= r_s2_vld;
      r_s3_mag  <= MW'(r_s2_mx) + MW'(r_s2_mn >> 1);
      r_s3_idx  <= r_s2_idx;
      r_s3_last <= r_s2_last;
      // Peak search; the report captures the candidate including the last bin, so a
      // following frame loading r_run_* in the next cycle cannot disturb it.
      if (r_s3_vld && w_searched) begin
        r_run_idx <= w_cand_idx;
        r_run_mag <= w_cand_mag;
      end
      r_peak_vld <= r_s3_vld && r_s3_last;
      if (r_s3_vld && r_s3_last) begin
        r_peak_idx <= w_cand_idx;
        r_peak_mag <= w_cand_mag;
      end
    end
  end

  assign o_mag_tvalid = r_s3_vld;
  assign o_mag_tdata  = r_s3_mag;
  assign o_mag_index  = r_s3_idx;
  assign o_mag_tlast  = r_s3_last;
  assign o_peak_vld   = r_peak_vld;
  assign o_peak_index = r_peak_idx;
  assign o_peak_mag   = r_peak_mag;

endmodule

// File: tb/tb_fft_spectrum_peak.sv
// tb/tb_fft_spectrum_peak.sv - self-checking bench for fft_spectrum_peak
module tb_fft_spectrum_peak;

  localparam int N    = 256;
  localparam int HALF = 128;
  localparam int MAXA = 16777215;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid, tlast;
  logic [63:0] tdata;
  logic [15:0] tuser;
  logic        o_mag_tvalid, o_mag_tlast, o_peak_vld, o_frame_err;
  logic [25:0] o_mag_tdata, o_peak_mag;
  logic [7:0]  o_mag_index, o_peak_index;

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_spectrum_peak dut (
    .i_aclk              (clk),
    .i_rst               (rst),
    .i_axi4s_data_tvalid (tvalid),
    .i_axi4s_data_tdata  (tdata),
    .i_axi4s_data_tlast  (tlast),
    .i_axi4s_data_tuser  (tuser),
    .o_mag_tvalid        (o_mag_tvalid),
    .o_mag_tdata         (o_mag_tdata),
    .o_mag_index         (o_mag_index),
    .o_mag_tlast         (o_mag_tlast),
    .o_peak_vld          (o_peak_vld),
    .o_peak_index        (o_peak_index),
    .o_peak_mag          (o_peak_mag),
    .o_frame_err         (o_frame_err)
  );

  typedef struct { int idx; int unsigned mag; bit last; longint cyc; } beat_t;
  typedef struct { int idx; int unsigned mag; longint cyc; } peak_t;
  typedef struct { int re; int im; int unsigned mag; } vec_t;

  beat_t  exp_beats[$];
  peak_t  exp_peaks[$];
  longint exp_errs[$];
  vec_t   tbl[8];

  int          checks = 0;
  int          errors = 0;
  int          f_re[N];
  int          f_im[N];
  int unsigned f_exp[N];
  int          last_peak_idx = 0;
  int unsigned last_peak_mag = 0;

  task automatic chk(string name, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int unsigned ref_abs(int v);
    int unsigned a;
    a = (v < 0) ? int'(-v) : int'(v);
    if (a > MAXA) a = MAXA;
    return a;
  endfunction

  function automatic int unsigned ref_mag(int re, int im);
    int unsigned a, b;
    a = ref_abs(re);
    b = ref_abs(im);
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  task automatic clear_frame();
    for (int b = 0; b < N; b++) begin
      f_re[b] = 0; f_im[b] = 0; f_exp[b] = 0;
    end
  endtask

  task automatic rand_frame(bit full);
    for (int b = 0; b < N; b++) begin
      if (!full) begin
        f_re[b] = int'($urandom_range(0, 1998)) - 999;
        f_im[b] = int'($urandom_range(0, 1998)) - 999;
      end else begin
        f_re[b] = ($urandom_range(0, 15) == 0) ? -16777216 : int'($urandom_range(0, 33554431)) - 16777216;
        f_im[b] = ($urandom_range(0, 15) == 0) ? -16777216 : int'($urandom_range(0, 33554431)) - 16777216;
      end
      f_exp[b] = ref_mag(f_re[b], f_im[b]);
    end
  endtask

  task automatic drive(int re, int im, int idx, bit last);
    logic [31:0] r32, i32;
    r32 = 32'(re);
    i32 = 32'(im);
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = {7'($urandom), i32[24:0], 7'($urandom), r32[24:0]};
    tuser  = {8'($urandom), 8'(idx)};
    tlast  = last;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'($urandom);
      tuser  = 16'($urandom);
      tdata  = {$urandom, $urandom};
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_mag_tvalid"}, o_mag_tvalid, 0);
    chk({tag, "_mag_tdata"},  o_mag_tdata,  0);
    chk({tag, "_mag_index"},  o_mag_index,  0);
    chk({tag, "_mag_tlast"},  o_mag_tlast,  0);
    chk({tag, "_peak_vld"},   o_peak_vld,   0);
    chk({tag, "_peak_index"}, o_peak_index, 0);
    chk({tag, "_peak_mag"},   o_peak_mag,   0);
    chk({tag, "_frame_err"},  o_frame_err,  0);
  endtask

  // Drives bins first..N-1 of the frame arrays. Only a frame starting at bin 0 is
  // expected to produce output; a cut asserts reset where bin 'cut' would go.
  task automatic send_frame(int first, int cut, bit gaps);
    beat_t e;
    peak_t p;
    for (int b = first; b < N; b++) begin
      if (b == cut) begin
        @(negedge clk);
        rst    = 1'b1;
        tvalid = 1'b0;
        while (exp_beats.size() > 0 && exp_beats[$].cyc > cyc) void'(exp_beats.pop_back());
        @(negedge clk);
        check_reset_outputs("mid_reset");
        last_peak_idx = 0;
        last_peak_mag = 0;
        rst = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
      drive(f_re[b], f_im[b], b, b == N - 1);
      if (first == 0 && b < HALF) begin
        e.idx = b; e.mag = f_exp[b]; e.last = (b == HALF - 1); e.cyc = cyc + 3;
        exp_beats.push_back(e);
        if (b == HALF - 1) begin
          p.idx = -1; p.mag = 0; p.cyc = cyc + 4;
          for (int k = 1; k < HALF; k++)
            if (p.idx < 0 || f_exp[k] > p.mag) begin p.idx = k; p.mag = f_exp[k]; end
          exp_peaks.push_back(p);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    while (exp_beats.size() > 0 && exp_beats[0].cyc < cyc) begin
      chk("beat_missing_idx", -1, exp_beats[0].idx);
      void'(exp_beats.pop_front());
    end
    if (o_mag_tvalid === 1'b1) begin
      if (exp_beats.size() > 0 && exp_beats[0].cyc == cyc) begin
        beat_t e;
        e = exp_beats.pop_front();
        chk("beat_idx",  o_mag_index, e.idx);
        chk("beat_mag",  o_mag_tdata, e.mag);
        chk("beat_last", o_mag_tlast, e.last);
      end else begin
        chk("beat_unexpected_idx", o_mag_index, -1);
      end
    end
    while (exp_peaks.size() > 0 && exp_peaks[0].cyc < cyc) begin
      chk("peak_missing_idx", -1, exp_peaks[0].idx);
      void'(exp_peaks.pop_front());
    end
    if (o_peak_vld === 1'b1) begin
      if (exp_peaks.size() > 0 && exp_peaks[0].cyc == cyc) begin
        peak_t p;
        p = exp_peaks.pop_front();
        chk("peak_idx", o_peak_index, p.idx);
        chk("peak_mag", o_peak_mag,   p.mag);
        last_peak_idx = p.idx;
        last_peak_mag = p.mag;
      end else begin
        chk("peak_unexpected_idx", o_peak_index, -1);
      end
    end
    while (exp_errs.size() > 0 && exp_errs[0] < cyc) begin
      chk("frame_err_missing", 0, 1);
      void'(exp_errs.pop_front());
    end
    if (o_frame_err === 1'b1) begin
      if (exp_errs.size() > 0 && exp_errs[0] == cyc) begin
        chk("frame_err", o_frame_err, 1);
        void'(exp_errs.pop_front());
      end else begin
        chk("frame_err_unexpected", 1, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{-300,      400,       550};
    tbl[1] = '{-16777216, 0,         16777215};
    tbl[2] = '{0,         -16777216, 16777215};
    tbl[3] = '{7,         3,         8};
    tbl[4] = '{-16777216, -16777216, 25165822};
    tbl[5] = '{16777215,  16777215,  25165822};
    tbl[6] = '{3,         -7,        8};
    tbl[7] = '{-1,        -1,        1};

    tvalid = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Single tone at bin 37
    clear_frame();
    f_re[37] = 1000; f_exp[37] = 1000;
    send_frame(0, N, 1'b0);
    idle(3);

    // Magnitude approximation table at bins 5..12
    clear_frame();
    for (int i = 0; i < 8; i++) begin
      f_re[5 + i] = tbl[i].re; f_im[5 + i] = tbl[i].im; f_exp[5 + i] = tbl[i].mag;
    end
    send_frame(0, N, 1'b0);
    idle(2);

    // Tie plus DC skip
    clear_frame();
    f_re[0] = 9000; f_exp[0] = 9000;
    f_re[10] = 500; f_exp[10] = 500;
    f_im[20] = -500; f_exp[20] = 500;
    send_frame(0, N, 1'b0);
    idle(2);

    // Reset mid-frame, stray tail, then a clean frame with a tone at bin 3
    rand_frame(1'b0);
    send_frame(0, 100, 1'b0);
    send_frame(101, N, 1'b0);
    clear_frame();
    f_re[3] = -7000; f_exp[3] = 7000;
    send_frame(0, N, 1'b0);
    idle(2);

    // Back-to-back frames: peaks at 12 then 40
    rand_frame(1'b0);
    f_re[12] = 50000; f_exp[12] = ref_mag(f_re[12], f_im[12]);
    send_frame(0, N, 1'b0);
    rand_frame(1'b0);
    f_im[40] = -60000; f_exp[40] = ref_mag(f_re[40], f_im[40]);
    send_frame(0, N, 1'b0);
    idle(4);

    // Randomized full-range frames with idle gaps
    for (int k = 0; k < 4; k++) begin
      rand_frame(1'b1);
      send_frame(0, N, 1'b1);
    end
    idle(4);

`ifdef FFT_SPEC_FRAME_CHECK_EN
    // Index jump 49 -> 51: error pulse, no peak, then a clean frame
    clear_frame();
    f_re[30] = 4000; f_exp[30] = 4000;
    for (int b = 0; b < 50; b++) begin
      beat_t e;
      drive(f_re[b], f_im[b], b, 1'b0);
      e.idx = b; e.mag = f_exp[b]; e.last = 1'b0; e.cyc = cyc + 3;
      exp_beats.push_back(e);
    end
    drive(0, 0, 51, 1'b0);
    exp_errs.push_back(cyc + 1);
    for (int b = 52; b < N; b++) drive(0, 0, b, b == N - 1);
    clear_frame();
    f_re[3] = 800; f_exp[3] = 800;
    send_frame(0, N, 1'b0);
    idle(4);
`endif

    idle(10);
    chk("pending_beats", exp_beats.size(), 0);
    chk("pending_peaks", exp_peaks.size(), 0);
    chk("pending_errs",  exp_errs.size(),  0);
    chk("held_peak_idx", o_peak_index, last_peak_idx);
    chk("held_peak_mag", o_peak_mag,   last_peak_mag);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
